// File: rtl/rti_capture_core_if.sv
// rti_capture_core_if: 128-bit valid/ready stream carrying captured entries to the read-side bridge.
interface rti_capture_core_if;
    logic [127:0] tdata;
    logic         tvalid;
    logic         tready;
    modport master (output tdata, output tvalid, input tready);
    modport slave (input tdata, input tvalid, output tready);
endinterface

// File: rtl/rti_capture_core.sv
// rti_capture_core: timestamps windowed input events against the RTIO counter.
// Accepted events are buffered in a storage FIFO that feeds a single output register.
module rti_capture_core #(
    parameter int DATA_WIDTH      = 64,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       rtio_clk,
    input  logic                       rtio_resetn,
    input  logic [63:0]                counter,
    input  logic                       capture_en,
    input  logic [63:0]                window_start,
    input  logic [63:0]                window_end,
    input  logic                       event_valid,
    input  logic [DATA_WIDTH-1:0]      event_data,
    input  logic                       flush,
    rti_capture_core_if.master         m,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_DEPTH_LOG2:0]   count,
    output logic                       overflow_error,
    output logic [15:0]                overflow_count
);
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    logic [127:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, st_count;
    logic [127:0] tdata_q, tdata_d, entry;
    logic         tvalid_q, tvalid_d, ovf_err_q, ovf_err_d;
    logic [15:0]  ovf_cnt_q, ovf_cnt_d;
    logic         accept, st_full, st_empty, pop, load, push, drop, mem_we;

    always_comb begin
        entry    = {counter, 64'(event_data)};
        accept   = capture_en && event_valid && counter >= window_start && counter < window_end;
        st_count = wr_ptr_q - rd_ptr_q;
        st_empty = wr_ptr_q == rd_ptr_q;
        st_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = tvalid_q && m.tready;
        load     = !st_empty && (!tvalid_q || pop);
        push     = accept && !st_full;
        drop     = accept && st_full;
        mem_we   = push && !flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        ovf_err_d = ovf_err_q;
        ovf_cnt_d = ovf_cnt_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            tvalid_d  = 1'b0;
            ovf_err_d = 1'b0;
            ovf_cnt_d = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (load) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                tdata_d  = mem_q[rd_ptr_q[AW-1:0]];
                tvalid_d = 1'b1;
            end else if (pop) begin
                tvalid_d = 1'b0;
            end
            if (drop) begin
                ovf_err_d = 1'b1;
                ovf_cnt_d = (ovf_cnt_q == 16'hFFFF) ? ovf_cnt_q : ovf_cnt_q + 16'd1;
            end
        end
    end

    // Storage needs no reset: pointers alone define which slots are live.
    always_ff @(posedge rtio_clk)
        if (mem_we)
            mem_q[wr_ptr_q[AW-1:0]] <= entry;

    always_ff @(posedge rtio_clk or negedge rtio_resetn)
        if (!rtio_resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            ovf_err_q <= 1'b0;
            ovf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            ovf_err_q <= ovf_err_d;
            ovf_cnt_q <= ovf_cnt_d;
        end

    assign m.tdata        = tdata_q;
    assign m.tvalid       = tvalid_q;
    assign full           = st_full;
    assign empty          = st_empty && !tvalid_q;
    assign count          = st_count + (AW+1)'(tvalid_q);
    assign overflow_error = ovf_err_q;
    assign overflow_count = ovf_cnt_q;
endmodule

// File: tb/tb_rti_capture_core.sv
// tb_rti_capture_core: scoreboard bench; expected entries queued at stimulus, compared on each stream transfer.
module tb_rti_capture_core;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic [63:0]  counter = '0, ws = '0, we = '0, ed = '0;
    logic         capture_en = 1'b0, ev = 1'b0, flush = 1'b0;
    logic         full, empty, ovf_err;
    logic [4:0]   count;
    logic [15:0]  ovf_cnt;
    int           n_chk = 0, n_fail = 0, pops = 0, p0;
    logic [127:0] sb[$];
    logic [127:0] hold_d;
    bit           hold_v = 1'b0;

    rti_capture_core_if s();

    rti_capture_core #(.DATA_WIDTH(64), .FIFO_DEPTH_LOG2(4)) dut (
        .rtio_clk(clk), .rtio_resetn(rst_n), .counter(counter), .capture_en(capture_en),
        .window_start(ws), .window_end(we), .event_valid(ev), .event_data(ed), .flush(flush),
        .m(s.master), .full(full), .empty(empty), .count(count),
        .overflow_error(ovf_err), .overflow_count(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev_at(input logic [63:0] c, input logic [63:0] d, input bit keep);
        counter = c;
        ed = d;
        ev = 1'b1;
        if (keep)
            sb.push_back({c, d});
        tick();
        ev = 1'b0;
    endtask

    task automatic drain(input string tag);
        s.tready = 1'b1;
        for (int i = 0; i < 80 && !empty; i++)
            tick();
        chk(tag, 128'(empty), 128'd1);
        chk({tag, "_sb"}, 128'(sb.size()), 128'd0);
        s.tready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", 128'(s.tvalid), 128'd1);
                chk("stall_data", s.tdata, hold_d);
            end
            if (s.tvalid && s.tready) begin
                pops++;
                if (sb.size() == 0)
                    chk("pop_without_expected", 128'(sb.size()), 128'd1);
                else
                    chk("sb_data", s.tdata, sb.pop_front());
            end
            hold_v = s.tvalid && !s.tready && !flush;
            hold_d = s.tdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        s.tready = 1'b0;
        #2;
        chk("rst_tvalid", 128'(s.tvalid), 128'd0);
        chk("rst_tdata", s.tdata, 128'd0);
        chk("rst_full", 128'(full), 128'd0);
        chk("rst_empty", 128'(empty), 128'd1);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_ovf", 128'({ovf_err, ovf_cnt}), 128'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        capture_en = 1'b1;
        we = '1;

        ev_at(64'd100, 64'hABCD, 1'b1);
        chk("single_lat_k", 128'(s.tvalid), 128'd0);
        tick();
        chk("single_lat_k1", 128'(s.tvalid), 128'd1);
        chk("single_data", s.tdata, {64'd100, 64'h0000_0000_0000_ABCD});
        chk("single_count", 128'(count), 128'd1);
        s.tready = 1'b1;
        tick();
        chk("single_empty", 128'(empty), 128'd1);
        s.tready = 1'b0;

        ws = 64'd200;
        we = 64'd205;
        s.tready = 1'b1;
        p0 = pops;
        for (longint c = 199; c <= 206; c++)
            ev_at(64'(c), 64'(c * 3), c >= 200 && c < 205);
        drain("window_drain");
        chk("window_pops", 128'(pops - p0), 128'd5);

        ws = 64'd300;
        we = 64'd300;
        for (longint c = 298; c <= 302; c++)
            ev_at(64'(c), 64'(c), 1'b0);
        tick();
        chk("degenerate_window", 128'(count), 128'd0);

        ws = '0;
        we = '1;
        p0 = pops;
        for (int i = 0; i < 20; i++)
            ev_at(64'(1000 + i), {$urandom, $urandom}, i < 17);
        chk("ovf_count_held", 128'(count), 128'd17);
        chk("ovf_full", 128'(full), 128'd1);
        chk("ovf_error", 128'(ovf_err), 128'd1);
        chk("ovf_dropped", 128'(ovf_cnt), 128'd3);
        drain("ovf_drain");
        chk("ovf_pops", 128'(pops - p0), 128'd17);

        s.tready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 30; i++) begin
            ev_at(64'(2000 + i), {$urandom, $urandom}, 1'b1);
            if (i >= 1)
                chk("stream_count", 128'(count), 128'd2);
        end
        drain("stream_drain");
        chk("stream_pops", 128'(pops - p0), 128'd30);
        chk("stream_no_drop", 128'(ovf_cnt), 128'd3);

        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            s.tready = (i % 2 == 0);
            ev_at(64'(4000 + i), {$urandom, $urandom}, 1'b1);
        end
        drain("stall_drain");
        chk("stall_pops", 128'(pops - p0), 128'd20);

        for (int i = 0; i < 5; i++)
            ev_at(64'(5000 + i), 64'(i), 1'b0);
        chk("flush_pre_count", 128'(count), 128'd5);
        chk("flush_pre_ovf", 128'(ovf_err), 128'd1);
        flush = 1'b1;
        counter = 64'd5005;
        ev = 1'b1;
        tick();
        flush = 1'b0;
        ev = 1'b0;
        chk("flush_empty", 128'(empty), 128'd1);
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_ovf", 128'({ovf_err, ovf_cnt}), 128'd0);
        tick();
        tick();
        chk("flush_event_dropped", 128'(count), 128'd0);

        for (int i = 0; i < 20; i++)
            ev_at(64'(6000 + i), 64'(i + 1), 1'b0);
        chk("reset_pre_count", 128'(count), 128'd17);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_tvalid", 128'(s.tvalid), 128'd0);
        chk("areset_tdata", s.tdata, 128'd0);
        chk("areset_full", 128'(full), 128'd0);
        chk("areset_empty", 128'(empty), 128'd1);
        chk("areset_count", 128'(count), 128'd0);
        chk("areset_ovf", 128'({ovf_err, ovf_cnt}), 128'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        ev_at(64'd7000, 64'h55, 1'b1);
        drain("post_reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rti_capture_core.md
# rti_capture_core

Real-time input (RTI) capture core: the receive-side counterpart of the timestamped output path. It timestamps input events against the shared 64-bit RTIO counter, gates them with a programmable capture window, and buffers them in a FIFO. It presents the captured entries as a 128-bit valid/ready stream to the AXI read-side bridge, which returns them to the host. The block sits entirely in the `rtio_clk` domain, beside the time controller that drives `counter`.

## Interface
- `DATA_WIDTH`, 64: event payload width (≤64); zero-extended into the low half of the entry.
- `FIFO_DEPTH_LOG2`, 4: storage FIFO depth is 2^FIFO_DEPTH_LOG2 entries, excluding the output register.

Ports:
- `rtio_clk` in 1: single clock for everything.
- `rtio_resetn` in 1: asynchronous, active-low reset.
- `counter` in 64: RTIO timeline counter.
- `capture_en` in 1: capture enable level.
- `window_start` in 64: first counter value accepted (inclusive).
- `window_end` in 64: counter bound (exclusive).
- `event_valid` in 1: input event strobe, one event per high cycle.
- `event_data` in DATA_WIDTH: event payload.
- `flush` in 1: synchronous clear of buffered data and error state.
- `m_tdata` out 128: entry, {timestamp[63:0], zero-extended data[63:0]}.
- `m_tvalid` out 1: entry available.
- `m_tready` in 1: consumer accepts the entry.
- `full` out 1: storage FIFO holds 2^FIFO_DEPTH_LOG2 entries.
- `empty` out 1: storage FIFO and output register both empty.
- `count` out FIFO_DEPTH_LOG2+1: total entries held, including the output register.
- `overflow_error` out 1: sticky; an accepted event was dropped.
- `overflow_count` out 16: number of dropped events, saturating at 16'hFFFF.

## Operation
- Accept condition: `capture_en && event_valid && counter >= window_start && counter < window_end`, using unsigned 64-bit compares. If `window_start >= window_end`, no events are accepted.
- The timestamp is the `counter` value in the same cycle `event_valid` is sampled high.
- Structure: a circular storage FIFO with write/read pointers of FIFO_DEPTH_LOG2+1 bits (the MSB distinguishes full from empty), feeding a single output register with `m_tvalid`.
- Output register refill: load from the storage head when the register is empty, or when it is being popped this cycle (`m_tvalid && m_tready`), and storage is non-empty.
- Push while `full`: the event is dropped, `overflow_error` is set, and `overflow_count` increments. This holds even if a pop occurs in the same cycle, because `full` is evaluated before the edge.
- Push while storage is empty and the output register is empty: the entry still goes through storage. There is no bypass.
- `flush` high: on that edge, both pointers are cleared, `m_tvalid` goes to 0, and `overflow_error` and `overflow_count` go to 0. An event in the same cycle is dropped and not counted. Flush takes priority over push and pop.
- `m_tdata` holds stable while `m_tvalid && !m_tready`.
- The window registers are not latched; a change takes effect the next cycle.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `full`=0, `empty`=1, `count`=0, `overflow_error`=0, `overflow_count`=0, pointers=0.
- Latency, event to `m_tvalid` with everything empty: the event is sampled at edge k and written to storage at edge k. The output register loads at edge k+1, so `m_tvalid` is high after edge k+1.
- Back-to-back pops: with storage non-empty, holding `m_tready` high sustains 1 entry/cycle.
- `full`, `empty` and `count` are registered, or derived from registered pointers plus `m_tvalid`. They reflect the state after the most recent edge.
- Throughput: 1 push and 1 pop per cycle simultaneously. Pushing at full with `m_tready` held high still drops.
- Reset assertion mid-operation discards all contents asynchronously.

## Test plan
- Single event: window [0, 2^64−1), `capture_en`=1, `counter`=100, `event_data`=0xABCD, one-cycle strobe -> `m_tvalid` high two edges later, `m_tdata`={64'd100, 64'h0000_0000_0000_ABCD}, `count`=1. Pop -> `empty`=1.
- Window gating: window [200, 205), events at counter 199 through 206 -> exactly 5 entries, timestamps 200–204.
- Overflow: `FIFO_DEPTH_LOG2`=4, `m_tready`=0, 20 consecutive events -> 17 entries held (16 storage + 1 output), `full`=1, `overflow_error`=1, `overflow_count`=3. Drain -> entries appear in order with the 17 earliest timestamps.
- Streaming: continuous events with `m_tready`=1 -> one entry per cycle, no drops, timestamps contiguous.
- Stall: `m_tready` toggling 1010… -> `m_tdata` is stable while stalled and no entries are lost or duplicated.
- Flush and reset: with 5 entries held and overflow set, pulse `flush` together with an event -> `empty`=1, `count`=0, `overflow_error`=0, and the event is not captured. Repeat using an async `rtio_resetn` pulse mid-cycle -> the reset values appear immediately.
